// File: rtl/mc_pkg.sv
// ============================================================================
// Module : mc_pkg
// Brief  : Shared encodings for the multicycle controller and its datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  localparam logic [1:0] c_srcb_reg   = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  typedef struct packed {
    logic       ir;
    logic       pcwrite;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_out_decode.sv
// ============================================================================
// Module : mc_out_decode
// Brief  : Current state to datapath strobes/selects (Moore plus handshake).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        // IR load and PC increment only commit in the cycle the fetch completes
        ctrl.memread = 1'b1;
        ctrl.alusrcb = c_srcb_four;
        ctrl.aluop   = c_aluop_add;
        ctrl.pcsrc   = c_pcsrc_alu;
        ctrl.ir      = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: ctrl.alusrcb = c_srcb_immsh;
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = c_srcb_imm;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = c_aluop_funct;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = c_aluop_sub;
        ctrl.pcsrc   = c_pcsrc_aluout;
        ctrl.pcwrite = zero;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = c_pcsrc_jump;
        ctrl.pcwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// Module : mc_control
// Brief  : Multicycle processor main control FSM with memory handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int SW  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Op,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           IR,
  output logic           PCWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           IorD,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           Illegal,
  output logic [SW-1:0]  State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_illegal;
  logic [5:0] w_op;
  ctrl_t      w_ctrl;
  ctrl_t      w_ctrl_q;

  assign w_op = 6'(Op);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    unique case (r_state)
      FETCH:  w_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        if (w_op == c_op_lw || w_op == c_op_sw) w_next = MEMADR;
        else if (w_op == c_op_rtype)            w_next = EXEC;
        else if (w_op == c_op_beq)              w_next = BRANCH;
        else if (w_op == c_op_addi)             w_next = ADDIEX;
        else if (w_op == c_op_j)                w_next = JUMP;
        else                                    w_illegal = 1'b1;
      end
      MEMADR: w_next = (w_op == c_op_lw) ? MEMRD : MEMWR;
      MEMRD:  w_next = MemReady ? MEMWB : MEMRD;
      MEMWR:  w_next = MemReady ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP and corrupt encodings go back to FETCH
      default: w_next = FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state     (r_state),
    .mem_ready (MemReady),
    .zero      (Zero),
    .ctrl      (w_ctrl)
  );

  // Reset forces every strobe low, even though the state already reads FETCH
  assign w_ctrl_q = RST ? '0 : w_ctrl;

  assign IR       = w_ctrl_q.ir;
  assign PCWrite  = w_ctrl_q.pcwrite;
  assign MemRead  = w_ctrl_q.memread;
  assign MemWrite = w_ctrl_q.memwrite;
  assign RegWrite = w_ctrl_q.regwrite;
  assign IorD     = w_ctrl_q.iord;
  assign MemtoReg = w_ctrl_q.memtoreg;
  assign RegDst   = w_ctrl_q.regdst;
  assign ALUSrcA  = w_ctrl_q.alusrca;
  assign ALUSrcB  = w_ctrl_q.alusrcb;
  assign ALUOp    = w_ctrl_q.aluop;
  assign PCSrc    = w_ctrl_q.pcsrc;
  assign Illegal  = w_illegal & ~RST;
  assign State    = SW'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// Module : tb_mc_control
// Brief  : Instruction-level reference model checking of mc_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_control;
  import mc_pkg::*;

  // instruction phases as seen by the programmer's model
  localparam int P_F = 0, P_D = 1, P_A = 2, P_RD = 3, P_MWB = 4, P_WR = 5;
  localparam int P_EX = 6, P_AWB = 7, P_BR = 8, P_IX = 9, P_IWB = 10, P_J = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       memready = 1'b0;
  logic       ir, pcwrite, memread, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       illegal;
  logic [3:0] state;
  int         total = 0;
  int         bad = 0;

  mc_control #(.OPW(6), .SW(4)) dut (
    .CLK(clk), .RST(rst), .Op(op), .Zero(zero), .MemReady(memready),
    .IR(ir), .PCWrite(pcwrite), .MemRead(memread), .MemWrite(memwrite),
    .RegWrite(regwrite), .IorD(iord), .MemtoReg(memtoreg), .RegDst(regdst),
    .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .ALUOp(aluop), .PCSrc(pcsrc),
    .Illegal(illegal), .State(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs_vec();
    return {ir, pcwrite, memread, memwrite, regwrite, iord, memtoreg, regdst,
            alusrca, alusrcb, aluop, pcsrc, illegal};
  endfunction

  function automatic bit known_op(logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // expected strobes for one cycle of a given phase
  function automatic logic [15:0] exp_vec(int ph, logic mrdy, logic z, logic [5:0] o);
    logic e_ir, e_pcw, e_mr, e_mw, e_rw, e_iord, e_m2r, e_rdst, e_asa, e_ill;
    logic [1:0] e_asb, e_aop, e_pcs;
    {e_ir, e_pcw, e_mr, e_mw, e_rw, e_iord, e_m2r, e_rdst, e_asa, e_ill} = '0;
    {e_asb, e_aop, e_pcs} = '0;
    case (ph)
      P_F:   begin e_mr = 1; e_asb = 2'b01; e_ir = mrdy; e_pcw = mrdy; end
      P_D:   begin e_asb = 2'b11; e_ill = !known_op(o); end
      P_A:   begin e_asa = 1; e_asb = 2'b10; end
      P_RD:  begin e_mr = 1; e_iord = 1; end
      P_MWB: begin e_rw = 1; e_m2r = 1; end
      P_WR:  begin e_mw = 1; e_iord = 1; end
      P_EX:  begin e_asa = 1; e_aop = 2'b10; end
      P_AWB: begin e_rw = 1; e_rdst = 1; end
      P_BR:  begin e_asa = 1; e_aop = 2'b01; e_pcs = 2'b01; e_pcw = z; end
      P_IX:  begin e_asa = 1; e_asb = 2'b10; end
      P_IWB: e_rw = 1;
      P_J:   begin e_pcs = 2'b10; e_pcw = 1; end
      default: ;
    endcase
    return {e_ir, e_pcw, e_mr, e_mw, e_rw, e_iord, e_m2r, e_rdst, e_asa, e_asb, e_aop, e_pcs, e_ill};
  endfunction

  function automatic state_t exp_state(int ph);
    case (ph)
      P_F: return FETCH;   P_D: return DECODE;   P_A: return MEMADR;
      P_RD: return MEMRD;  P_MWB: return MEMWB;  P_WR: return MEMWR;
      P_EX: return EXEC;   P_AWB: return ALUWB;  P_BR: return BRANCH;
      P_IX: return ADDIEX; P_IWB: return ADDIWB; default: return JUMP;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_quiet(input string tag);
    check({tag, " strobes"}, 32'(obs_vec()), 32'd0);
    check({tag, " state"}, 32'(state), 32'(FETCH));
  endtask

  // runs one instruction from FETCH; call at #1 after a rising edge
  task automatic run_instr(input logic [5:0] iop, input logic iz, input int fstall, input int mstall);
    int phases[$];
    int ircount;
    ircount = 0;
    phases = {P_F, P_D};
    if (iop == 6'b100011)      phases = {phases, P_A, P_RD, P_MWB};
    else if (iop == 6'b101011) phases = {phases, P_A, P_WR};
    else if (iop == 6'b000000) phases = {phases, P_EX, P_AWB};
    else if (iop == 6'b000100) phases = {phases, P_BR};
    else if (iop == 6'b001000) phases = {phases, P_IX, P_IWB};
    else if (iop == 6'b000010) phases = {phases, P_J};
    foreach (phases[i]) begin
      int  n;
      bit  memph;
      memph = phases[i] inside {P_F, P_RD, P_WR};
      n = memph ? ((phases[i] == P_F) ? fstall : mstall) + 1 : 1;
      for (int k = 0; k < n; k++) begin
        op       = (phases[i] == P_D || phases[i] == P_A) ? iop : 6'($urandom);
        zero     = (phases[i] == P_BR) ? iz : 1'($urandom);
        memready = memph ? (k == n - 1) : 1'($urandom);
        #1;
        check($sformatf("strobes op=%b ph=%0d k=%0d", iop, phases[i], k),
              32'(obs_vec()), 32'(exp_vec(phases[i], memready, zero, op)));
        check($sformatf("state op=%b ph=%0d k=%0d", iop, phases[i], k),
              32'(state), 32'(exp_state(phases[i])));
        check("memrd_memwr_excl", 32'(memread & memwrite), 32'd0);
        ircount += int'(ir);
        @(posedge clk); #1;
      end
    end
    check($sformatf("ir_once op=%b", iop), 32'(ircount), 32'd1);
  endtask

  initial begin
    logic [5:0] rop;
    logic [5:0] ops [6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    // power-on reset: everything quiet before any clock edge
    #3;
    check_reset_quiet("por_early");
    repeat (2) @(posedge clk);
    #1;
    check_reset_quiet("por_held");
    rst = 1'b0;
    @(posedge clk); #1;

    run_instr(6'b100011, 1'b0, 0, 0);   // lw, no stalls
    run_instr(6'b101011, 1'b0, 0, 3);   // sw, three wait cycles
    run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b000000, 1'b0, 0, 0);   // R-type
    run_instr(6'b001000, 1'b0, 0, 0);   // addi
    run_instr(6'b000010, 1'b0, 0, 0);   // j
    run_instr(6'b111111, 1'b0, 0, 0);   // illegal
    run_instr(6'b100011, 1'b0, 2, 2);   // lw with fetch and read stalls

    // reset pulse in the middle of a MEMRD stall
    op = 6'b100011; memready = 1'b1; zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    memready = 1'b0;
    @(posedge clk); #1;
    check("stall_state", 32'(state), 32'(MEMRD));
    check("stall_memread", 32'(memread), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_quiet("midstall");
    @(posedge clk); #2;
    check_reset_quiet("midstall_held");
    rst = 1'b0;
    @(posedge clk); #1;
    run_instr(6'b100011, 1'b0, 0, 1);

    // randomized instruction stream
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 6'($urandom);
        if (known_op(rop)) rop = 6'b111110;
      end else begin
        rop = ops[$urandom_range(0, 5)];
      end
      run_instr(rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have parameter SW, default 4, state-encoding width.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 Op  input  OPW  opcode from instruction register output bits [31:26].
REQ-006 Zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 MemReady  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-008 IR  output  1  instruction-register enable.
REQ-009 PCWrite, MemRead, MemWrite, RegWrite, IorD, MemtoReg, RegDst, ALUSrcA  output  1 each  datapath strobes/selects.
REQ-010 ALUSrcB, ALUOp, PCSrc  output  2 each  ALU-B mux, ALU op class (00 add, 01 sub, 10 funct), PC mux (00 ALU, 01 ALUOut, 10 jump).
REQ-011 Illegal  output  1  one-cycle pulse on unknown opcode.
REQ-012 State  output  SW  current state, debug.

Function
REQ-013 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IR=PCWrite=MemReady; stay while MemReady=0, else go to DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP, otherwise FETCH with Illegal=1 for that cycle.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMRD if Op=100011, else MEMWR.
REQ-017 MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then go to MEMWB.
REQ-018 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; go to FETCH.
REQ-019 MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then go to FETCH.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go to ALUWB.
REQ-021 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; go to FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero; go to FETCH.
REQ-023 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to ADDIWB.
REQ-024 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; go to FETCH.
REQ-025 JUMP: PCSrc=10, PCWrite=1; go to FETCH.
REQ-026 Every output not listed for a state SHALL be 0 in that state.
REQ-027 Outputs SHALL be combinational from State; IR, PCWrite and Illegal may additionally depend on MemReady, Zero and Op as stated above.
REQ-028 IR SHALL be 1 in exactly one cycle per instruction.
REQ-029 MemRead and MemWrite SHALL never be 1 together.
REQ-030 An unknown encoding in the state register SHALL recover to FETCH on the next edge.
REQ-031 Op SHALL be consumed only in DECODE and MEMADR; its value in other states SHALL have no effect.

Reset
REQ-032 RST=1 SHALL force State=FETCH immediately, without waiting for a clock edge.
REQ-033 While RST=1, all outputs SHALL be 0, including IR and MemRead.
REQ-034 Reset asserted in the middle of an instruction, including a stall in MEMRD or MEMWR, SHALL abandon that instruction.
REQ-035 After RST falls, FETCH SHALL begin on the first rising edge.

Structure
REQ-036 State encodings, opcode constants and ALUOp/PCSrc codes SHALL live in shared package mc_pkg, also used by the datapath.
REQ-037 Next-state logic and output decode SHALL be in this module; an optional sub-module mc_out_decode (state to strobes) is permitted.

Verification
REQ-038 Reset then lw (Op=100011), MemReady always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; IR=1 only in cycle 1; RegWrite=1, MemtoReg=1 in cycle 5.
REQ-039 sw with MemReady=0 for 3 cycles in MEMWR -> MemWrite held 4 cycles, IorD=1, then FETCH; RegWrite stays 0.
REQ-040 beq with Zero=1, then beq with Zero=0 -> PCWrite=1, PCSrc=01 in the first BRANCH; PCWrite=0 in the second.
REQ-041 R-type, addi, j in sequence -> 4, 4, 3 cycles respectively; RegDst=1 only in ALUWB; j gives PCSrc=10, PCWrite=1.
REQ-042 Op=111111 -> Illegal=1 for one cycle in DECODE, return to FETCH, no write strobes asserted.
REQ-043 RST pulse mid-clock during a MEMRD stall -> State=FETCH and MemRead=0 before the next edge; normal fetch resumes after release.
